// File: rtl/div_by_subtraction.sv
// Sequential unsigned divider using repeated subtraction.
// It uses the same start/done handshake as the multiply-by-repeated-addition unit.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; overrides start and aborts a running divide
//   start        division request, accepted only in IDLE or DONE
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         high in CHECK and SUB
//   done         high in DONE; quotient, remainder and div_by_zero are valid
//   quotient     quotient register
//   remainder    remainder register
//   div_by_zero  high together with done when the divisor was zero
module div_by_subtraction #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StSub   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dz_q, dz_d;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          r_d     = dividend;
          d_d     = divisor;
          q_d     = '0;
          dz_d    = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (d_q == '0) begin
          dz_d    = 1'b1;
          q_d     = '0;
          state_d = StDone;
        end else begin
          state_d = StSub;
        end
      end
      StSub: begin
        // The R >= D guard rules out underflow. Q is bounded by the dividend, so it cannot wrap.
        if (r_q >= d_q) begin
          r_d = r_q - d_q;
          q_d = q_q + 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = (state_q == StCheck) || (state_q == StSub);
  assign done        = (state_q == StDone);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_by_subtraction.sv
// Self-checking bench for div_by_subtraction.
// A 16-bit instance and an 8-bit instance share the clock and the reset.
// An arithmetic model predicts the handshake and the results on every cycle.
// Directed runs check the results and latencies against hand-computed values.
module tb_div_by_subtraction;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start16 = 1'b0, start8 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;

  logic        busy16, done16, dz16, busy8, done8, dz8;
  logic [15:0] q16, r16;
  logic [7:0]  q8, r8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_by_subtraction #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dz16)
  );

  div_by_subtraction #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic model: latency and results come straight from division, not from a state machine.
  logic        in_st [2];
  logic [15:0] in_a  [2];
  logic [15:0] in_b  [2];
  assign in_st[0] = start16;
  assign in_st[1] = start8;
  assign in_a[0]  = a16;
  assign in_a[1]  = {8'd0, a8};
  assign in_b[0]  = b16;
  assign in_b[1]  = {8'd0, b8};

  logic        m_busy [2];
  logic        m_done [2];
  logic        m_dz   [2];
  int          m_cnt  [2];
  logic [15:0] m_q    [2];
  logic [15:0] m_r    [2];
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_dz[k]   <= 1'b0;
        m_q[k]    <= '0;
        m_r[k]    <= '0;
        m_cnt[k]  <= 0;
      end else if (!m_busy[k] && in_st[k]) begin
        m_busy[k] <= 1'b1;
        m_done[k] <= 1'b0;
        if (in_b[k] == 16'd0) begin
          m_q[k]   <= '0;
          m_r[k]   <= in_a[k];
          m_dz[k]  <= 1'b1;
          m_cnt[k] <= 1;
        end else begin
          m_q[k]   <= in_a[k] / in_b[k];
          m_r[k]   <= in_a[k] % in_b[k];
          m_dz[k]  <= 1'b0;
          m_cnt[k] <= int'(in_a[k] / in_b[k]) + 2;
        end
      end else if (m_busy[k]) begin
        m_cnt[k] <= m_cnt[k] - 1;
        if (m_cnt[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
        end
      end
    end
    if (rst) model_valid <= 1'b1;
  end

  // Every cycle: the handshake must always match; the results must match whenever they are defined.
  always @(negedge clk) begin
    if (model_valid) begin
      check("busy16", {31'd0, busy16}, {31'd0, m_busy[0]});
      check("done16", {31'd0, done16}, {31'd0, m_done[0]});
      check("busy8", {31'd0, busy8}, {31'd0, m_busy[1]});
      check("done8", {31'd0, done8}, {31'd0, m_done[1]});
      if (!m_busy[0]) begin
        check("q16", {16'd0, q16}, {16'd0, m_q[0]});
        check("r16", {16'd0, r16}, {16'd0, m_r[0]});
        check("dz16", {31'd0, dz16}, {31'd0, m_dz[0]});
      end
      if (!m_busy[1]) begin
        check("q8", {24'd0, q8}, {16'd0, m_q[1]});
        check("r8", {24'd0, r8}, {16'd0, m_r[1]});
        check("dz8", {31'd0, dz8}, {31'd0, m_dz[1]});
      end
    end
  end

  function automatic logic dn(input int sel);
    return (sel == 0) ? done16 : done8;
  endfunction

  task automatic drive(input int sel, input logic s, input logic [15:0] a, input logic [15:0] b);
    if (sel == 0) begin
      start16 = s; a16 = a; b16 = b;
    end else begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // Pulse start for one cycle, then measure the number of edges from acceptance until done.
  task automatic run(input int sel, input logic [15:0] a, input logic [15:0] b, input int eq,
                     input int er, input int edz, input int elat, input string nm);
    int cnt;
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(negedge clk);
    drive(sel, 1'b0, a, b);
    cnt = 0;
    while (!dn(sel) && cnt < elat + 10) begin
      @(negedge clk);
      cnt++;
    end
    check({nm, " latency"}, cnt, elat);
    if (sel == 0) begin
      check({nm, " quotient"}, {16'd0, q16}, eq);
      check({nm, " remainder"}, {16'd0, r16}, er);
      check({nm, " div_by_zero"}, {31'd0, dz16}, edz);
    end else begin
      check({nm, " quotient"}, {24'd0, q8}, eq);
      check({nm, " remainder"}, {24'd0, r8}, er);
      check({nm, " div_by_zero"}, {31'd0, dz8}, edz);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy16}, 0);
    check("reset done", {31'd0, done16}, 0);
    check("reset quotient", {16'd0, q16}, 0);
    check("reset remainder", {16'd0, r16}, 0);
    rst = 1'b0;

    run(0, 16'd100, 16'd7, 14, 2, 0, 16, "100/7");
    run(0, 16'd5, 16'd9, 0, 5, 0, 2, "5/9");
    run(0, 16'd0, 16'd3, 0, 0, 0, 2, "0/3");
    run(0, 16'd1234, 16'd0, 0, 1234, 1, 1, "1234/0");
    run(0, 16'd20, 16'd4, 5, 0, 0, 7, "20/4");
    run(1, 16'd255, 16'd1, 255, 0, 0, 257, "w8 255/1");

    // A start pulse while busy must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 16'd200, 16'd10);
    @(negedge clk);
    drive(0, 1'b0, 16'd200, 16'd10);
    repeat (5) @(negedge clk);
    drive(0, 1'b1, 16'd9, 16'd3);
    @(negedge clk);
    drive(0, 1'b0, 16'd9, 16'd3);
    cnt = 6;
    while (!done16 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("200/10 latency", cnt, 22);
    check("200/10 quotient", {16'd0, q16}, 20);
    check("200/10 remainder", {16'd0, r16}, 0);
    run(0, 16'd9, 16'd3, 3, 0, 0, 5, "9/3 from done");

    // A reset pulse in the middle of SUB aborts the operation.
    @(negedge clk);
    drive(0, 1'b1, 16'd1000, 16'd3);
    @(negedge clk);
    drive(0, 1'b0, 16'd1000, 16'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'd0, busy16}, 0);
    check("abort done", {31'd0, done16}, 0);
    check("abort quotient", {16'd0, q16}, 0);
    check("abort remainder", {16'd0, r16}, 0);
    run(0, 16'd7, 16'd2, 3, 1, 0, 5, "7/2");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
